shared_buf_arbiter: RTL
=======================

SHARED_BUF_ARBITER -- requirements
Module: shared_buf_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16: width of hold-timeout counter and limit input.
REQ-002 SHALL have parameter IP_FIRST, default 1: when 1, the IP wins the first simultaneous contest after reset.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  block enable; low forces IDLE and zero grants.
REQ-006 ip_req  in  1  IP request pulse or level (HLS ap_vld style).
REQ-007 ip_rel  in  1  IP release pulse.
REQ-008 cpu_req  in  1  CPU request, level or pulse.
REQ-009 cpu_rel  in  1  CPU release pulse.
REQ-010 timeout_cycles  in  TIMEOUT_W  maximum hold cycles per grant; 0 = unlimited.
REQ-011 ip_grant  out  1  IP owns the buffer.
REQ-012 cpu_grant  out  1  CPU owns the buffer.
REQ-013 owner  out  2  00 none, 01 IP, 10 CPU.
REQ-014 timeout_evt  out  1  one-cycle pulse when a grant is revoked by timeout.
REQ-015 grant_cnt  out  16  number of grants issued, wraps 0xFFFF->0x0000.

Function
REQ-016 SHALL implement states IDLE, GRANT_IP, GRANT_CPU.
REQ-017 ip_grant SHALL equal enable AND (state==GRANT_IP); cpu_grant SHALL be the analogous signal for GRANT_CPU; the two SHALL never both be 1.
REQ-018 In IDLE: ip_req only -> GRANT_IP; cpu_req only -> GRANT_CPU; no request -> stay in IDLE.
REQ-019 In IDLE with both requests: grant the requester that is not last_owner (round-robin); after reset, last_owner SHALL be CPU if IP_FIRST=1, else IP.
REQ-020 Grant latency SHALL be one cycle: a request sampled in IDLE at edge N gives grant high after edge N.
REQ-021 In GRANT_x, x_rel SHALL return to IDLE on the next edge and set last_owner=x; the grant drops the same edge.
REQ-022 After a release or timeout, the block SHALL spend at least one cycle in IDLE with no grant before any new grant.
REQ-023 Releases from the non-owner SHALL be ignored; requests during a grant SHALL be ignored unless still asserted when the block is in IDLE.
REQ-024 Simultaneous req and rel from the owner SHALL be treated as a release only.
REQ-025 grant_cnt SHALL increment by 1 on each IDLE->GRANT_x transition.
REQ-026 enable low SHALL move the block to IDLE synchronously on the next edge; last_owner and grant_cnt SHALL hold.

Reset
REQ-027 On rst_n low: state=IDLE, ip_grant=0, cpu_grant=0, owner=00, timeout_evt=0, grant_cnt=0, hold counter=0, last_owner per REQ-019.
REQ-028 Deassertion of rst_n SHALL be usable synchronously.
REQ-029 Reset mid-grant SHALL drop the grant immediately and asynchronously.

Configuration
REQ-030 Macro SHARED_BUF_ARB_TIMEOUT_EN defined: the hold counter clears on grant entry and increments each GRANT cycle.
REQ-031 With the macro defined and timeout_cycles!=0: when the count reaches timeout_cycles, the block SHALL go to IDLE, pulse timeout_evt for one cycle, and set last_owner to the revoked owner.
REQ-032 Macro undefined: no hold counter; timeout_evt tied 0; timeout_cycles ignored.
REQ-033 With the macro defined, a release in the same cycle as a timeout SHALL count as a release; timeout_evt SHALL stay 0.

Structure
REQ-034 State encodings and owner codes SHALL live in the shared config header, beside the existing buffer-size defines.
REQ-035 The hold timer SHALL be sub-module arb_hold_timer (clear, inc, limit, expired), present only under SHARED_BUF_ARB_TIMEOUT_EN.
REQ-036 The block SHALL replace the per-buffer app_data, UDP RX and UDP TX arbiters in the Ethernet top, with one instance each.

Verification
REQ-037 Both requests high in cycle 1 after reset, IP_FIRST=1 -> ip_grant=1 at cycle 2, owner=01, grant_cnt=1.
REQ-038 IP releases while cpu_req is held -> one IDLE cycle, then cpu_grant=1, grant_cnt=2; next contest goes to IP.
REQ-039 Macro defined, timeout_cycles=5, CPU never releases -> cpu_grant low after 5 grant cycles, timeout_evt one pulse.
REQ-040 cpu_rel pulsed during GRANT_IP -> no change; enable dropped mid-grant -> both grants 0 next cycle, grant_cnt held.
REQ-041 rst_n asserted during GRANT_CPU -> cpu_grant 0 with no clock; after release, outputs at reset values.
REQ-042 grant_cnt preloaded via 65535 grants -> wraps to 0 on the next grant.

Source files
------------

// File: rtl/shared_buf_arbiter_pkg.sv
// Shared arbiter configuration: buffer sizes, state encodings and owner codes.
// Used by shared_buf_arbiter and its optional hold timer.
package shared_buf_arbiter_pkg;

    localparam int APP_DATA_BUF_DEPTH = 2048;
    localparam int UDP_RX_BUF_DEPTH   = 2048;
    localparam int UDP_TX_BUF_DEPTH   = 2048;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_GRANT_IP  = 2'b01,
        ST_GRANT_CPU = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IP   = 2'b01;
    localparam logic [1:0] OWNER_CPU  = 2'b10;

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold timer: counts cycles a grant has been held and flags expiry.
// Only compiled in when SHARED_BUF_ARB_TIMEOUT_EN is defined.
`ifdef SHARED_BUF_ARB_TIMEOUT_EN
module arb_hold_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   cnt_next;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire on the cycle whose increment would reach the limit, so a limit
    // of N gives exactly N cycles of grant. >= covers a limit lowered mid-grant.
    assign cnt_next = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    assign expired  = (limit != '0) && (cnt_next >= {1'b0, limit});

endmodule
`endif

// File: rtl/shared_buf_arbiter.sv
// Two-requester (IP / CPU) round-robin arbiter for a shared buffer.
// Optional hold timeout enabled by defining SHARED_BUF_ARB_TIMEOUT_EN.
module shared_buf_arbiter
    import shared_buf_arbiter_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter bit IP_FIRST  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 ip_req,
    input  logic                 ip_rel,
    input  logic                 cpu_req,
    input  logic                 cpu_rel,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    output logic                 ip_grant,
    output logic                 cpu_grant,
    output logic [1:0]           owner,
    output logic                 timeout_evt,
    output logic [15:0]          grant_cnt
);

    arb_state_e  state_q, state_d;
    logic        last_cpu_q, last_cpu_d;
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic        timeout_evt_q, timeout_evt_d;
    logic        expired;

`ifdef SHARED_BUF_ARB_TIMEOUT_EN
    logic hold_clear;
    logic hold_inc;

    // Counter sits at zero while idle, so it is already clear on grant entry.
    assign hold_clear = (state_q == ST_IDLE);
    assign hold_inc   = (state_q != ST_IDLE);

    arb_hold_timer #(
        .W (TIMEOUT_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hold_clear),
        .inc     (hold_inc),
        .limit   (timeout_cycles),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_cpu_d    = last_cpu_q;
        grant_cnt_d   = grant_cnt_q;
        timeout_evt_d = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ip_req && (!cpu_req || last_cpu_q)) begin
                        state_d     = ST_GRANT_IP;
                        grant_cnt_d = grant_cnt_q + 16'd1;
                    end else if (cpu_req) begin
                        state_d     = ST_GRANT_CPU;
                        grant_cnt_d = grant_cnt_q + 16'd1;
                    end
                end
                // Release takes priority over expiry, so no timeout pulse then.
                ST_GRANT_IP: begin
                    if (ip_rel || expired) begin
                        state_d       = ST_IDLE;
                        last_cpu_d    = 1'b0;
                        timeout_evt_d = !ip_rel;
                    end
                end
                ST_GRANT_CPU: begin
                    if (cpu_rel || expired) begin
                        state_d       = ST_IDLE;
                        last_cpu_d    = 1'b1;
                        timeout_evt_d = !cpu_rel;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_cpu_q    <= IP_FIRST;
            grant_cnt_q   <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_cpu_q    <= last_cpu_d;
            grant_cnt_q   <= grant_cnt_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign ip_grant    = enable && (state_q == ST_GRANT_IP);
    assign cpu_grant   = enable && (state_q == ST_GRANT_CPU);
    assign owner       = ip_grant ? OWNER_IP : (cpu_grant ? OWNER_CPU : OWNER_NONE);
    assign timeout_evt = timeout_evt_q;
    assign grant_cnt   = grant_cnt_q;

endmodule
